video_bus_arbiter: RTL and testbench

- Shares the single video-subsystem write bus (`video_cs` / `video_wr` / `video_addr` / `video_wr_data`) between NUM_REQ masters, e.g. CPU MMIO bridge, blitter, sprite loader.
- Sits directly upstream of the video controller's address decoder.
- Round-robin arbitration, with optional locked bursts bounded by MAX_BURST to prevent starvation.
- Bus outputs are registered; one write is issued per cycle.

---
 rtl/video_bus_arbiter.sv | 156 +++++++++++++++
 tb/tb_video_bus_arbiter.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/video_bus_arbiter.sv
// Round-robin arbiter for the shared video write bus, with locked bursts
// capped at MAX_BURST beats and a registered bus stage toward the video controller.
module video_bus_arbiter #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned MAX_BURST = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_REQ-1:0]      req,
  input  logic [NUM_REQ-1:0]      lock,
  input  logic [NUM_REQ-1:0]      wr,
  input  logic [NUM_REQ-1:0][20:0] addr,
  input  logic [NUM_REQ-1:0][31:0] wr_data,
  output logic [NUM_REQ-1:0]      gnt,
  output logic                    video_cs,
  output logic                    video_wr,
  output logic [20:0]             video_addr,
  output logic [31:0]             video_wr_data,
  output logic                    locked,
  output logic [2:0]              owner
);

  localparam int unsigned ADDR_W = 21;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned PTR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CNT_W  = $clog2(MAX_BURST + 1);

  typedef enum logic {ARB, OWNED} state_e;

  state_e              state_q, state_d;
  logic [PTR_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]    own_q, own_d;
  logic [CNT_W-1:0]    burst_cnt_q, burst_cnt_d;
  logic                video_cs_q, video_cs_d;
  logic                video_wr_q, video_wr_d;
  logic [ADDR_W-1:0]   video_addr_q, video_addr_d;
  logic [DATA_W-1:0]   video_wr_data_q, video_wr_data_d;

  logic [NUM_REQ-1:0]  gnt_c;
  logic [PTR_W-1:0]    win_c;
  logic [PTR_W-1:0]    idx_c;
  logic                found_c;
  logic                xfer_c;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return PTR_W'((32'(p) + 32'd1) % NUM_REQ);
  endfunction

  // Grant: owner-only while OWNED, otherwise first requester from rr_ptr onward
  always_comb begin
    gnt_c   = '0;
    found_c = 1'b0;
    idx_c   = '0;
    if (!reset) begin
      if (state_q == OWNED) begin
        gnt_c[own_q] = req[own_q];
      end else begin
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
          idx_c = PTR_W'((32'(rr_ptr_q) + k) % NUM_REQ);
          if (!found_c && req[idx_c]) begin
            gnt_c[idx_c] = 1'b1;
            found_c      = 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    win_c = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (gnt_c[i]) win_c = PTR_W'(i);
    end
  end

  assign xfer_c = |gnt_c;

  always_comb begin
    state_d         = state_q;
    rr_ptr_d        = rr_ptr_q;
    own_d           = own_q;
    burst_cnt_d     = burst_cnt_q;
    video_cs_d      = xfer_c;
    video_wr_d      = xfer_c & wr[win_c];
    video_addr_d    = video_addr_q;
    video_wr_data_d = video_wr_data_q;

    if (xfer_c) begin
      video_addr_d    = addr[win_c];
      video_wr_data_d = wr_data[win_c];
    end

    case (state_q)
      ARB: begin
        if (xfer_c) begin
          rr_ptr_d = next_ptr(win_c);
          own_d    = win_c;
          if (lock[win_c] && (MAX_BURST > 1)) begin
            state_d     = OWNED;
            burst_cnt_d = CNT_W'(1);
          end
        end
      end
      OWNED: begin
        // Any exit from ownership clears the burst count
        if (req[own_q]) begin
          rr_ptr_d = next_ptr(own_q);
          if (lock[own_q] && ((32'(burst_cnt_q) + 32'd1) != MAX_BURST)) begin
            burst_cnt_d = burst_cnt_q + CNT_W'(1);
          end else begin
            state_d     = ARB;
            burst_cnt_d = '0;
          end
        end else begin
          state_d     = ARB;
          burst_cnt_d = '0;
        end
      end
      default: begin
        state_d     = ARB;
        burst_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= ARB;
      rr_ptr_q        <= '0;
      own_q           <= '0;
      burst_cnt_q     <= '0;
      video_cs_q      <= 1'b0;
      video_wr_q      <= 1'b0;
      video_addr_q    <= '0;
      video_wr_data_q <= '0;
    end else begin
      state_q         <= state_d;
      rr_ptr_q        <= rr_ptr_d;
      own_q           <= own_d;
      burst_cnt_q     <= burst_cnt_d;
      video_cs_q      <= video_cs_d;
      video_wr_q      <= video_wr_d;
      video_addr_q    <= video_addr_d;
      video_wr_data_q <= video_wr_data_d;
    end
  end

  assign gnt           = gnt_c;
  assign video_cs      = video_cs_q;
  assign video_wr      = video_wr_q;
  assign video_addr    = video_addr_q;
  assign video_wr_data = video_wr_data_q;
  assign locked        = (state_q == OWNED);
  assign owner         = 3'(own_q);

endmodule

// File: tb/tb_video_bus_arbiter.sv
// Directed bench for video_bus_arbiter: expected grants are fixed per step,
// expected bus beats go through a scoreboard queue and are checked one cycle later.
module tb_video_bus_arbiter;

  typedef struct packed {
    logic        wr;
    logic [20:0] addr;
    logic [31:0] data;
  } beat_t;

  logic             clk;
  logic             reset;
  logic [3:0]       req_r, lock_r, wr_r;
  logic [3:0][20:0] addr_r;
  logic [3:0][31:0] data_r;
  logic [3:0]       gnt;
  logic             video_cs, video_wr, locked;
  logic [20:0]      video_addr;
  logic [31:0]      video_wr_data;
  logic [2:0]       owner;

  beat_t       sb[$];
  logic [20:0] last_addr;
  logic [31:0] last_data;
  int          n_assert;
  int          n_fail;

  video_bus_arbiter #(.NUM_REQ(4), .MAX_BURST(16)) dut (
    .clk          (clk),
    .reset        (reset),
    .req          (req_r),
    .lock         (lock_r),
    .wr           (wr_r),
    .addr         (addr_r),
    .wr_data      (data_r),
    .gnt          (gnt),
    .video_cs     (video_cs),
    .video_wr     (video_wr),
    .video_addr   (video_addr),
    .video_wr_data(video_wr_data),
    .locked       (locked),
    .owner        (owner)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One bus cycle: check grant mid-cycle, then check the registered bus after the edge
  task automatic cycle(input logic [3:0] exp_gnt, input logic exp_lk, input string tag);
    beat_t b;
    beat_t e;
    @(negedge clk);
    chk({tag, ":gnt"}, 64'(gnt), 64'(exp_gnt));
    for (int i = 0; i < 4; i++) begin
      if (exp_gnt[i]) begin
        b.wr   = wr_r[i];
        b.addr = addr_r[i];
        b.data = data_r[i];
        sb.push_back(b);
      end
    end
    @(posedge clk);
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, ":cs"},   64'(video_cs),      64'(1'b1));
      chk({tag, ":wr"},   64'(video_wr),      64'(e.wr));
      chk({tag, ":addr"}, 64'(video_addr),    64'(e.addr));
      chk({tag, ":data"}, 64'(video_wr_data), 64'(e.data));
      last_addr = e.addr;
      last_data = e.data;
    end else begin
      chk({tag, ":idle_cs"},   64'(video_cs),      64'(1'b0));
      chk({tag, ":idle_wr"},   64'(video_wr),      64'(1'b0));
      chk({tag, ":hold_addr"}, 64'(video_addr),    64'(last_addr));
      chk({tag, ":hold_data"}, 64'(video_wr_data), 64'(last_data));
    end
    chk({tag, ":locked"}, 64'(locked), 64'(exp_lk));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: timeout observed, completion expected");
    $fatal(1, "watchdog");
  end

  initial begin
    clk       = 1'b0;
    reset     = 1'b1;
    n_assert  = 0;
    n_fail    = 0;
    last_addr = '0;
    last_data = '0;
    req_r     = 4'b1111;
    lock_r    = 4'b0000;
    wr_r      = 4'b1011;
    for (int i = 0; i < 4; i++) begin
      addr_r[i] = 21'(32'h1000 * i + 32'h55);
      data_r[i] = 32'hC0DE_0000 + 32'(i);
    end

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst:gnt",    64'(gnt),           64'(4'b0000));
    chk("rst:cs",     64'(video_cs),      64'(1'b0));
    chk("rst:wr",     64'(video_wr),      64'(1'b0));
    chk("rst:addr",   64'(video_addr),    64'(21'h0));
    chk("rst:data",   64'(video_wr_data), 64'(32'h0));
    chk("rst:locked", 64'(locked),        64'(1'b0));
    chk("rst:owner",  64'(owner),         64'(3'd0));
    reset = 1'b0;

    // simultaneous requests rotate through all masters
    for (int r = 0; r < 2; r++) begin
      cycle(4'b0001, 1'b0, "simul");
      cycle(4'b0010, 1'b0, "simul");
      cycle(4'b0100, 1'b0, "simul");
      cycle(4'b1000, 1'b0, "simul");
    end
    chk("simul:owner", 64'(owner), 64'(3'd3));

    // move rr_ptr to 2, then a 4-beat locked burst from master 2
    req_r = 4'b0010;
    cycle(4'b0010, 1'b0, "prep");
    req_r  = 4'b0101;
    lock_r = 4'b0100;
    cycle(4'b0100, 1'b1, "burst1");
    cycle(4'b0100, 1'b1, "burst2");
    cycle(4'b0100, 1'b1, "burst3");
    lock_r = 4'b0000;
    cycle(4'b0100, 1'b0, "burst4");
    cycle(4'b0001, 1'b0, "burst_next");
    req_r = 4'b0000;
    cycle(4'b0000, 1'b0, "gap");

    // forced release after MAX_BURST beats
    req_r  = 4'b1010;
    lock_r = 4'b0010;
    for (int b = 1; b <= 16; b++) cycle(4'b0010, (b < 16), "force");
    cycle(4'b1000, 1'b0, "force_other");
    cycle(4'b0010, 1'b1, "force_regain");
    req_r  = 4'b0000;
    lock_r = 4'b0000;
    cycle(4'b0000, 1'b0, "force_drop");

    // owner drops req while OWNED
    req_r  = 4'b0001;
    lock_r = 4'b0001;
    cycle(4'b0001, 1'b1, "drop_own");
    cycle(4'b0001, 1'b1, "drop_own");
    req_r  = 4'b0010;
    lock_r = 4'b0000;
    cycle(4'b0000, 1'b0, "drop_gap");
    req_r = 4'b0011;
    cycle(4'b0010, 1'b0, "drop_resume");
    chk("drop:owner", 64'(owner), 64'(3'd1));

    // asynchronous reset in the middle of a locked burst
    req_r  = 4'b0001;
    lock_r = 4'b0001;
    for (int b = 0; b < 5; b++) cycle(4'b0001, 1'b1, "pre_rst");
    #2;
    reset = 1'b1;
    #1;
    chk("arst:cs",     64'(video_cs),      64'(1'b0));
    chk("arst:wr",     64'(video_wr),      64'(1'b0));
    chk("arst:addr",   64'(video_addr),    64'(21'h0));
    chk("arst:data",   64'(video_wr_data), 64'(32'h0));
    chk("arst:locked", 64'(locked),        64'(1'b0));
    chk("arst:gnt",    64'(gnt),           64'(4'b0000));
    chk("arst:owner",  64'(owner),         64'(3'd0));
    @(posedge clk);
    #1;
    reset     = 1'b0;
    last_addr = '0;
    last_data = '0;
    req_r     = 4'b0010;
    lock_r    = 4'b0000;
    cycle(4'b0010, 1'b0, "post_rst");

    // single write then idle bus
    addr_r[3] = 21'h100040;
    data_r[3] = 32'hDEADBEEF;
    wr_r[3]   = 1'b1;
    req_r     = 4'b1000;
    cycle(4'b1000, 1'b0, "single");
    req_r = 4'b0000;
    for (int i = 0; i < 3; i++) cycle(4'b0000, 1'b0, "idle");
    chk("idle:owner", 64'(owner), 64'(3'd3));
    chk("idle:sb_empty", 64'(sb.size()), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
